mem_burst_writer: RTL and testbench
===================================

Name: mem_burst_writer

Overview:
Write-side counterpart to the team's synchronous read-only memory: owns a DEPTH x DATA_W array and fills it from a valid/ready byte stream in bursts. A burst is programmed with a base address and a length. The address auto-increments and wraps modulo DEPTH. An independent registered read port, with the same 1-cycle latency as the ROM, lets downstream logic read back the contents.

Parameters:
DATA_W, 8, data width of each memory word
ADDR_W, 10, address width; DEPTH = 2**ADDR_W (1024)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  1-cycle burst request, sampled only in IDLE
base_addr  input  ADDR_W  first write address, captured on accepted start
length  input  ADDR_W+1  words in burst, 0..DEPTH, captured on accepted start
in_valid  input  1  write data valid
in_data  input  DATA_W  write data
in_ready  output  1  writer accepts in_data this cycle
busy  output  1  burst in progress
done  output  1  1-cycle pulse at burst completion
wr_count  output  ADDR_W+1  words written in current/last burst
address  input  ADDR_W  read address
dataout  output  DATA_W  registered read data

Behaviour:
- Reset (rst=0, asynchronous): FSM->IDLE; in_ready=0, busy=0, done=0, wr_count=0, dataout=0; internal address/remaining counters=0. Memory array is not reset, and its contents survive reset. Unwritten locations are undefined.
- FSM states: IDLE, WRITE, DONE.
- IDLE, start=1: capture base_addr into wr_addr, capture length into remaining, clear wr_count.
  - length!=0 -> WRITE.
  - length==0 -> DONE with no writes.
  - start in any other state is ignored.
- WRITE: in_ready=1, busy=1.
  - Each cycle with in_valid&&in_ready: mem[wr_addr]<=in_data; wr_addr<=wr_addr+1 mod DEPTH (1023->0 wrap); remaining-=1; wr_count+=1.
  - The handshake that drops remaining to 0 moves FSM to DONE.
  - in_valid=0 stalls with no side effects.
- DONE: busy=0, in_ready=0, done=1 for exactly one cycle -> IDLE. wr_count holds its final value until the next accepted start.
- Throughput: one word per cycle. A burst of N (N>=1) takes N handshake cycles plus 1 DONE cycle. done is asserted on the cycle after the last handshake edge.
- length==DEPTH: every location is written once; the address returns to base_addr.
- Read port:
  - Every rising edge, dataout<=mem[address].
  - Latency 1 cycle, no enable.
  - Read and write to the same address on the same edge returns the OLD data (read-before-write). The new data is visible on the next read.
- Reset mid-burst: FSM aborts to IDLE. Words already written stay in memory. No done pulse. wr_count=0.
- in_data is ignored whenever in_ready=0.

Decomposition:
- Shared package mem_pkg: DATA_W/ADDR_W defaults, DEPTH constant, state enum {IDLE, WRITE, DONE}.
- One sub-module: mem_array_1r1w. It holds the storage, has one synchronous write port (we, waddr, wdata) and one registered read port with read-before-write semantics, and has no reset on the array. It is reset only on its dataout register.
- The FSM, counters and handshake live in mem_burst_writer.

Test Plan:
1. Reset with rst=0 mid-simulation -> all outputs 0 asynchronously, without waiting for a clock edge.
2. Basic burst: start, base=10, length=4, in_data stream A0,A1,A2,A3 with in_valid held high.
   - Required: 4 handshakes, then done pulses 1 cycle with wr_count=4.
   - Readback at 10..13 returns A0..A3, each 1 cycle after address is applied.
3. Wrap and stall: base=1022, length=3, data 11,22,33, with in_valid deasserted for 2 cycles between words.
   - Required: mem[1022]=11, mem[1023]=22, mem[0]=33.
   - No writes during stall cycles. done fires only after the 3rd handshake.
4. length=0 -> no in_ready assertion, done pulses the cycle after start, wr_count=0, memory unchanged. length=1024 from base=0 with data=index[7:0] -> readback mem[k]==k[7:0] for all k.
5. Read/write collision: mem[5]=0x55 written first. Then burst base=5, length=1, data 0xAA, with address=5 held.
   - Required: dataout=0x55 on the write edge, 0xAA on the following edge.
6. Reset mid-burst: base=100, length=8; assert rst after the 3rd handshake.
   - Required: no done pulse; mem[100..102] retain their data.
   - A start while busy (before reset) is ignored and base/length are unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst-writer memory slice.
// Word/address widths, derived depth and the writer FSM encoding.
package mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_burst_writer_if.sv
// Burst-programming and write-stream handshake between a data source and the writer.
interface mem_burst_writer_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;

    modport master (
        output start, base_addr, length, in_valid, in_data,
        input  in_ready, busy, done, wr_count
    );

    modport slave (
        input  start, base_addr, length, in_valid, in_data,
        output in_ready, busy, done, wr_count
    );

endinterface

// File: rtl/mem_array_1r1w.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// A same-edge read of the address being written returns the old word.
module mem_array_1r1w
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dataout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking updates make the read sample the pre-write word, giving read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout <= '0;
        end else begin
            dataout <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_burst_writer.sv
// Fills an internal memory from a valid/ready stream in programmed bursts,
// wrapping the write address modulo DEPTH; independent 1-cycle read port.
module mem_burst_writer
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_burst_writer_if.slave      bus,
    input  logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      dataout
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   wr_count_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              we;

    // in_ready_r is high exactly while in WRITE, so it doubles as the write qualifier.
    assign we = bus.in_valid && in_ready_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_addr    <= '0;
            remaining  <= '0;
            wr_count_r <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        wr_addr    <= bus.base_addr;
                        remaining  <= bus.length;
                        wr_count_r <= '0;
                        if (bus.length != '0) begin
                            state      <= WRITE;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (we) begin
                        wr_addr    <= wr_addr + 1'b1;
                        remaining  <= remaining - CNT_ONE;
                        wr_count_r <= wr_count_r + CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state      <= DONE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.wr_count = wr_count_r;

    mem_array_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (wr_addr),
        .wdata   (bus.in_data),
        .raddr   (address),
        .dataout (dataout)
    );

endmodule

// File: tb/tb_mem_burst_writer.sv
// Scoreboard bench for mem_burst_writer: the driver predicts done pulses and read data
// from an array model of the memory; a negedge monitor pops and compares.
module tb_mem_burst_writer;
    import mem_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] dataout;

    mem_burst_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_burst_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .address (address),
        .dataout (dataout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: memory contents plus which locations have been written.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_vld [DEPTH];

    typedef struct {
        int cyc;
        int cnt;
    } done_exp_t;

    done_exp_t     done_q [$];
    logic [DW-1:0] rd_q [$];
    int            cyc = 0;
    logic          rd_req = 1'b0;
    logic          rd_req_d = 1'b0;
    int            exp_ready = 0;
    int            exp_count = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    // Monitor: compares every cycle, pops a done expectation when its cycle arrives.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("busy", 32'(bus.busy), 32'(exp_ready));
            check("wr_count", 32'(bus.wr_count), 32'(exp_count));
            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("done_wr_count", 32'(bus.wr_count), 32'(done_q[0].cnt));
                void'(done_q.pop_front());
            end else begin
                check("done_quiet", 32'(bus.done), 32'd0);
            end
            if (rd_req_d) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_queue: got read with no expectation at %0t", $time);
                end else begin
                    check("dataout", 32'(dataout), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] bdata [$];
    int            bgaps [$];

    task automatic fill(input int len, input int gap_max, input int mode);
        bdata.delete();
        bgaps.delete();
        for (int k = 0; k < len; k++) begin
            bdata.push_back(mode == 1 ? DW'(k) : DW'($urandom));
            bgaps.push_back(gap_max == 0 ? 0 : int'($urandom_range(gap_max, 0)));
        end
    endtask

    // Burst of bdata with bgaps stall cycles before each word; optionally aborted by reset
    // after abort_after handshakes, optionally with a start pulse injected mid-burst.
    task automatic run_burst(input int base, input int len, input int abort_after, input bit inject);
        int p;
        int s;
        p = len;
        for (int k = 0; k < len; k++) p += bgaps[k];
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.length    = (AW + 1)'(len);
        s = cyc;
        if (abort_after < 0) done_q.push_back('{s + 1 + p, len});
        tick();
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.length    = (AW + 1)'($urandom);
        exp_count = 0;
        exp_ready = (len != 0) ? 1 : 0;
        for (int k = 0; k < len; k++) begin
            for (int g = 0; g < bgaps[k]; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = bdata[k];
            if (inject && k == 1) begin
                bus.start     = 1'b1;
                bus.base_addr = AW'(500);
                bus.length    = (AW + 1)'(2);
            end
            tick();
            bus.start = 1'b0;
            ref_mem[(base + k) % DEPTH] = bdata[k];
            ref_vld[(base + k) % DEPTH] = 1'b1;
            exp_count++;
            if (k == len - 1) exp_ready = 0;
            if (abort_after == k + 1) break;
        end
        bus.in_valid = 1'b0;
        if (abort_after > 0) begin
            exp_ready = 0;
            exp_count = 0;
            #2 rst = 1'b0;
            #1;
            check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("async_rst_busy", 32'(bus.busy), 32'd0);
            check("async_rst_done", 32'(bus.done), 32'd0);
            check("async_rst_wr_count", 32'(bus.wr_count), 32'd0);
            check("async_rst_dataout", 32'(dataout), 32'd0);
            @(posedge clk);
            #1 rst = 1'b1;
        end else begin
            tick();
        end
    endtask

    task automatic read_range(input int a0, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (a0 + i) % DEPTH;
            if (!ref_vld[a]) continue;
            address = AW'(a);
            rd_req  = 1'b1;
            rd_q.push_back(ref_mem[a]);
            tick();
        end
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;

        #1 rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_wr_count", 32'(bus.wr_count), 32'd0);
        check("reset_dataout", 32'(dataout), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic burst at 10..13.
        bdata = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        bgaps = '{0, 0, 0, 0};
        run_burst(10, 4, -1, 1'b0);
        read_range(10, 4);

        // Wrap across 1023->0 with two-cycle stalls between words.
        bdata = '{8'd11, 8'd22, 8'd33};
        bgaps = '{0, 2, 2};
        run_burst(1022, 3, -1, 1'b0);
        read_range(1022, 3);

        // Zero-length burst with junk offered on the stream: nothing may be written.
        bdata.delete();
        bgaps.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        run_burst(10, 0, -1, 1'b0);
        read_range(10, 1);

        // Full-depth burst from 0.
        fill(DEPTH, 0, 1);
        run_burst(0, DEPTH, -1, 1'b0);
        read_range(0, DEPTH);

        // Read/write collision on address 5.
        bdata = '{8'h55};
        bgaps = '{0};
        run_burst(5, 1, -1, 1'b0);
        address       = AW'(5);
        bus.start     = 1'b1;
        bus.base_addr = AW'(5);
        bus.length    = (AW + 1)'(1);
        done_q.push_back('{cyc + 2, 1});
        tick();
        bus.start    = 1'b0;
        exp_count    = 0;
        exp_ready    = 1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        rd_req       = 1'b1;
        rd_q.push_back(ref_mem[5]);
        tick();
        bus.in_valid = 1'b0;
        ref_mem[5]   = 8'hAA;
        exp_count    = 1;
        exp_ready    = 0;
        rd_q.push_back(ref_mem[5]);
        tick();
        rd_req = 1'b0;
        tick();

        // Randomized bursts with random stalls.
        for (int b = 0; b < 6; b++) begin
            int base;
            int len;
            base = int'($urandom_range(DEPTH - 1, 0));
            len  = int'($urandom_range(16, 1));
            fill(len, 2, 0);
            run_burst(base, len, -1, 1'b0);
            read_range(base, len);
        end

        // Reset after the 3rd handshake, with an ignored start injected mid-burst.
        address = AW'(10);
        tick();
        fill(8, 0, 0);
        run_burst(100, 8, 3, 1'b1);
        read_range(100, 8);
        read_range(500, 2);

        // Recovery burst after the abort.
        fill(5, 1, 0);
        run_burst(200, 5, -1, 1'b0);
        read_range(200, 5);

        for (int i = 0; i < 20 && (done_q.size() > 0 || rd_q.size() > 0); i++) tick();
        if (done_q.size() > 0 || rd_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d done and %0d read expectations pending, required 0",
                     done_q.size(), rd_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
